// File: rtl/spi_regfile_if.sv
// SPI pin bundle between a mode-0 serial master and spi_regfile.
interface spi_regfile_if;
  logic sclk;
  logic sdi;
  logic cs;
  logic sdo;

  modport master (
    output sclk,
    output sdi,
    output cs,
    input  sdo
  );

  modport slave (
    input  sclk,
    input  sdi,
    input  cs,
    output sdo
  );
endinterface

// File: rtl/spi_regfile.sv
// SPI (mode 0) slave exposing a small register file. Frames are R/W bit, address, data,
// all MSB first; the SPI pins are resynchronised into clk and writes commit after cs rises.
module spi_regfile #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_regfile_if.slave               spi,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int AW1     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_ADDR  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [AW1-1:0]   NUM_REGS_C = AW1'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic sdi_meta_r, sdi_sync_r;
  logic cs_meta_r, cs_sync_r, cs_prev_r;
  logic sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;

  logic [CNT_W-1:0]   cnt_r;
  logic [FRAME_W-1:0] shift_r, shift_nxt_s;
  logic [DATA_W-1:0]  tx_r, rd_data_s;
  logic               rd_active_r, sdo_r;

  logic [DATA_W-1:0]  regs_r [NUM_REGS];
  logic               wr_strobe_r, frame_err_r;
  logic [ADDR_W-1:0]  wr_addr_r;

  logic               clear_s, shift_en_s, do_write_s, do_err_s, load_tx_s;
  logic               frame_rw_s, addr_ok_s;
  logic [ADDR_W-1:0]  frame_addr_s, rd_addr_s;
  logic [DATA_W-1:0]  frame_data_s;

  // Two-flop synchronizers plus one extra stage for edge detection; cs idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_prev_r <= 1'b0;
      sdi_meta_r  <= 1'b0;
      sdi_sync_r  <= 1'b0;
      cs_meta_r   <= 1'b1;
      cs_sync_r   <= 1'b1;
      cs_prev_r   <= 1'b1;
    end else begin
      sclk_meta_r <= spi.sclk;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      sdi_meta_r  <= spi.sdi;
      sdi_sync_r  <= sdi_meta_r;
      cs_meta_r   <= spi.cs;
      cs_sync_r   <= cs_meta_r;
      cs_prev_r   <= cs_sync_r;
    end
  end

  assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_sync_r & sclk_prev_r;
  assign cs_fall_s   = cs_prev_r & ~cs_sync_r;
  assign cs_rise_s   = ~cs_prev_r & cs_sync_r;

  assign shift_nxt_s  = {shift_r[FRAME_W-2:0], sdi_sync_r};
  assign frame_rw_s   = shift_r[FRAME_W-1];
  assign frame_addr_s = shift_r[DATA_W +: ADDR_W];
  assign frame_data_s = shift_r[DATA_W-1:0];
  assign addr_ok_s    = ({1'b0, frame_addr_s} < NUM_REGS_C);
  // The address is complete when this shift brings the count to 1+ADDR_W; R/W=0 starts a read.
  assign rd_addr_s    = shift_nxt_s[ADDR_W-1:0];
  assign load_tx_s    = shift_en_s && (cnt_r == CNT_ADDR) && !shift_nxt_s[ADDR_W];

  // Read mux; addresses at or beyond NUM_REGS match no register and return zero.
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_REGS; k++) begin
      rd_data_s = rd_data_s | ({DATA_W{rd_addr_s == ADDR_W'(k)}} & regs_r[k]);
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-cycle control decisions, including the commit verdict.
  always_comb begin
    state_nxt_s = state_r;
    clear_s     = 1'b0;
    shift_en_s  = 1'b0;
    do_write_s  = 1'b0;
    do_err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_nxt_s = ST_SHIFT;
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cs_rise_s) begin
          state_nxt_s = ST_COMMIT;
        end else if (sclk_rise_s && !cs_sync_r) begin
          shift_en_s = 1'b1;
        end else begin
          shift_en_s = 1'b0;
        end
      end
      ST_COMMIT: begin
        state_nxt_s = ST_IDLE;
        if (cnt_r != CNT_FRAME) begin
          do_err_s = 1'b1;
        end else if (frame_rw_s && addr_ok_s) begin
          do_write_s = 1'b1;
        end else if (frame_rw_s) begin
          do_err_s = 1'b1;
        end else begin
          do_err_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Receive shifter, saturating bit counter and read-data transmit shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {CNT_W{1'b0}};
      shift_r     <= {FRAME_W{1'b0}};
      tx_r        <= {DATA_W{1'b0}};
      rd_active_r <= 1'b0;
    end else if (clear_s) begin
      cnt_r       <= {CNT_W{1'b0}};
      shift_r     <= {FRAME_W{1'b0}};
      tx_r        <= {DATA_W{1'b0}};
      rd_active_r <= 1'b0;
    end else if (shift_en_s) begin
      shift_r <= shift_nxt_s;
      if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if (load_tx_s) begin
        tx_r        <= rd_data_s;
        rd_active_r <= 1'b1;
      end
    end else if (state_r == ST_COMMIT) begin
      rd_active_r <= 1'b0;
    end else if (sclk_fall_s && rd_active_r && !cs_sync_r) begin
      tx_r <= {tx_r[DATA_W-2:0], 1'b0};
    end
  end

  // Serial output: presents the next tx bit on each sclk falling edge, forced low otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdo_r <= 1'b0;
    end else if (cs_sync_r || !rd_active_r) begin
      sdo_r <= 1'b0;
    end else if (sclk_fall_s) begin
      sdo_r <= tx_r[DATA_W-1];
    end
  end

  // Register file update and the commit status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_r[k] <= {DATA_W{1'b0}};
      end
      wr_strobe_r <= 1'b0;
      frame_err_r <= 1'b0;
      wr_addr_r   <= {ADDR_W{1'b0}};
    end else begin
      wr_strobe_r <= do_write_s;
      frame_err_r <= do_err_s;
      if (do_write_s) begin
        wr_addr_r <= frame_addr_s;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (frame_addr_s == ADDR_W'(k)) begin
            regs_r[k] <= frame_data_s;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs[g*DATA_W +: DATA_W] = regs_r[g];
  end

  assign spi.sdo   = sdo_r;
  assign wr_strobe = wr_strobe_r;
  assign wr_addr   = wr_addr_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_regfile.sv
// Directed bench for spi_regfile: default-parameter instance plus a 16x16 instance.
module tb_spi_regfile;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk_b = 1'b0;
  logic sdi_b = 1'b0;
  logic cs0_b = 1'b1;
  logic cs16_b = 1'b1;

  always #5 clk = ~clk;

  spi_regfile_if spi0 ();
  spi_regfile_if spi16 ();

  assign spi0.sclk  = sclk_b;
  assign spi0.sdi   = sdi_b;
  assign spi0.cs    = cs0_b;
  assign spi16.sclk = sclk_b;
  assign spi16.sdi  = sdi_b;
  assign spi16.cs   = cs16_b;

  logic [39:0]  regs0;
  logic         ws0, fe0;
  logic [6:0]   wa0;
  logic [255:0] regs16;
  logic         ws16, fe16;
  logic [3:0]   wa16;

  spi_regfile dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi0),
    .regs      (regs0),
    .wr_strobe (ws0),
    .wr_addr   (wa0),
    .frame_err (fe0)
  );

  spi_regfile #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi16),
    .regs      (regs16),
    .wr_strobe (ws16),
    .wr_addr   (wa16),
    .frame_err (fe16)
  );

  int checks = 0;
  int errors = 0;
  int ws0_cnt = 0, fe0_cnt = 0, ws16_cnt = 0, fe16_cnt = 0;
  int ws0_base, fe0_base, ws16_base, fe16_base;
  logic [31:0] rx;

  always @(posedge clk) begin
    if (ws0)  ws0_cnt  <= ws0_cnt + 1;
    if (fe0)  fe0_cnt  <= fe0_cnt + 1;
    if (ws16) ws16_cnt <= ws16_cnt + 1;
    if (fe16) fe16_cnt <= fe16_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    ws0_base  = ws0_cnt;
    fe0_base  = fe0_cnt;
    ws16_base = ws16_cnt;
    fe16_base = fe16_cnt;
  endtask

  // Called at a negedge; drops cs, clocks nbits MSB first, samples sdo before each rising sclk.
  task automatic send_bits(input bit sel16, input logic [31:0] frame, input int nbits, input bit end_cs);
    if (sel16) cs16_b = 1'b0; else cs0_b = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi_b = frame[i];
      repeat (6) @(negedge clk);
      rx = {rx[30:0], (sel16 ? spi16.sdo : spi0.sdo)};
      sclk_b = 1'b1;
      repeat (6) @(negedge clk);
      sclk_b = 1'b0;
    end
    repeat (6) @(negedge clk);
    if (end_cs) begin
      if (sel16) cs16_b = 1'b1; else cs0_b = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    rx = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_regs",      regs0,         64'h0);
    check("reset_wr_addr",   wa0,           64'h0);
    check("reset_strobe",    ws0,           64'h0);
    check("reset_frame_err", fe0,           64'h0);
    check("reset_sdo",       spi0.sdo,      64'h0);
    check("reset_regs16",    regs16[63:0],  64'h0);

    // Write 0x83,0xA5 with exact commit latency from raw cs rise.
    snap();
    send_bits(1'b0, 32'h83A5, 16, 1'b0);
    cs0_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("wr_not_early", regs0[31:24], 64'h0);
    @(posedge clk);
    #1;
    check("wr_latency_reg3", regs0[31:24], 64'hA5);
    check("wr_latency_strobe", ws0, 64'h1);
    repeat (8) @(negedge clk);
    check("wr_regs",       regs0, 64'h00A5000000);
    check("wr_addr",       wa0, 64'h3);
    check("wr_strobe_cnt", ws0_cnt - ws0_base, 64'h1);
    check("wr_no_err",     fe0_cnt - fe0_base, 64'h0);

    // Out-of-range write address.
    snap();
    send_bits(1'b0, 32'h8511, 16, 1'b1);
    check("oob_regs",      regs0, 64'h00A5000000);
    check("oob_err_cnt",   fe0_cnt - fe0_base, 64'h1);
    check("oob_no_strobe", ws0_cnt - ws0_base, 64'h0);

    // Short (15-bit) and long (17-bit) write frames.
    snap();
    send_bits(1'b0, 32'h41D2, 15, 1'b1);
    check("short_err_cnt", fe0_cnt - fe0_base, 64'h1);
    check("short_regs",    regs0, 64'h00A5000000);
    snap();
    send_bits(1'b0, 32'h1074B, 17, 1'b1);
    check("long_err_cnt",  fe0_cnt - fe0_base, 64'h1);
    check("long_regs",     regs0, 64'h00A5000000);
    check("long_no_strobe", ws0_cnt - ws0_base, 64'h0);

    // Write regs[2]=0x3C then read it back over sdo.
    send_bits(1'b0, 32'h823C, 16, 1'b1);
    check("wr2_regs", regs0, 64'h00A53C0000);
    snap();
    send_bits(1'b0, 32'h0200, 16, 1'b1);
    check("rd_data",      rx[7:0], 64'h3C);
    check("rd_regs",      regs0, 64'h00A53C0000);
    check("rd_no_strobe", ws0_cnt - ws0_base, 64'h0);
    check("rd_no_err",    fe0_cnt - fe0_base, 64'h0);
    check("rd_sdo_idle",  spi0.sdo, 64'h0);
    check("rd_wr_addr",   wa0, 64'h2);

    // Read of an unimplemented address returns zero.
    snap();
    send_bits(1'b0, 32'h7F00, 16, 1'b1);
    check("rd_oob_data", rx[7:0], 64'h0);
    check("rd_oob_no_err", fe0_cnt - fe0_base, 64'h0);

    // Reset after 10 bits of a write to addr 1, then a fresh full frame.
    snap();
    send_bits(1'b0, 32'h205, 10, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_regs",   regs0, 64'h0);
    check("midrst_waddr",  wa0, 64'h0);
    check("midrst_strobe", ws0, 64'h0);
    check("midrst_err",    fe0, 64'h0);
    check("midrst_sdo",    spi0.sdo, 64'h0);
    @(negedge clk);
    cs0_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    send_bits(1'b0, 32'h815A, 16, 1'b1);
    check("post_rst_regs",  regs0, 64'h0000005A00);
    check("post_rst_waddr", wa0, 64'h1);
    check("post_rst_no_err", fe0_cnt - fe0_base, 64'h0);

    // Wide instance: back-to-back writes with a 4-clk cs gap, second to the top address.
    snap();
    send_bits(1'b1, 32'h17BEEF, 21, 1'b0);
    cs16_b = 1'b1;
    repeat (4) @(negedge clk);
    send_bits(1'b1, 32'h1F1234, 21, 1'b1);
    check("b2b_reg7",       regs16[7*16 +: 16], 64'hBEEF);
    check("b2b_reg15",      regs16[15*16 +: 16], 64'h1234);
    check("b2b_reg0",       regs16[15:0], 64'h0);
    check("b2b_strobe_cnt", ws16_cnt - ws16_base, 64'h2);
    check("b2b_no_err",     fe16_cnt - fe16_base, 64'h0);
    check("b2b_waddr",      wa16, 64'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_regfile.md
SPI_REGFILE -- requirements
Module: spi_regfile

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 5, number of DATA_W-bit registers (1..2**ADDR_W).
REQ-002 The block SHALL have parameter ADDR_W, default 7, width of the address field.
REQ-003 The block SHALL have parameter DATA_W, default 8, width of each register and of the data field.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 sclk  input  1  SPI serial clock, asynchronous to clk, idle low (mode 0).
REQ-008 sdi  input  1  SPI serial data in, MSB first.
REQ-009 cs  input  1  active-low chip select, asynchronous.
REQ-010 sdo  output  1  SPI serial data out, read data MSB first.
REQ-011 regs  output  NUM_REGS*DATA_W  flattened register file; register k at bits [k*DATA_W +: DATA_W].
REQ-012 wr_strobe  output  1  one-clk pulse when a register is written.
REQ-013 wr_addr  output  ADDR_W  address of the last committed write; valid with wr_strobe and held afterwards.
REQ-014 frame_err  output  1  one-clk pulse when a frame is rejected.

Function
REQ-015 sclk, sdi and cs SHALL each pass through a 2-flop synchronizer; a third flop on synced sclk SHALL provide edge detection.
REQ-016 A frame SHALL be FRAME_W = 1+ADDR_W+DATA_W bits: bit 0 (first) is R/W (1=write), then the address MSB first, then the data MSB first.
REQ-017 FSM states SHALL be IDLE, SHIFT and COMMIT.
REQ-018 IDLE->SHIFT SHALL occur on synced cs falling; the bit counter and shift register SHALL clear on entry.
REQ-019 In SHIFT, each synced sclk rising edge with synced cs low SHALL shift the synced sdi into the LSB; the counter SHALL saturate at FRAME_W+1.
REQ-020 An sclk edge detected in the same clk cycle that synced cs is high SHALL be ignored.
REQ-021 On the rising edge that completes the address (count becomes 1+ADDR_W) with R/W=0, the block SHALL load the tx shifter with regs[addr], or with 0 if addr >= NUM_REGS.
REQ-022 During read data phase, sdo SHALL update to the next tx bit on each synced sclk falling edge; sdo SHALL be 0 whenever synced cs is high or no read is active.
REQ-023 SHIFT->COMMIT SHALL occur on synced cs rising.
REQ-024 In COMMIT, a write SHALL be accepted iff count == FRAME_W, R/W=1 and addr < NUM_REGS; an accepted write SHALL update regs[addr], pulse wr_strobe and set wr_addr in the same cycle.
REQ-025 In COMMIT, a write with a wrong count or addr >= NUM_REGS SHALL leave regs unchanged and pulse frame_err.
REQ-026 In COMMIT, a read with count != FRAME_W SHALL pulse frame_err; a correct read SHALL have no side effect.
REQ-027 COMMIT->IDLE SHALL always take one cycle, so write latency is 4 clk from raw cs rise.
REQ-028 Correct operation is required for sclk high and low phases each >= 4 clk periods, and cs high time between frames >= 4 clk periods.

Reset
REQ-029 On rst_n low, all regs, the shift/tx registers and the counter SHALL be 0; synchronizers SHALL be 0 with synced cs at 1; the FSM SHALL be in IDLE; sdo, wr_strobe and frame_err SHALL be 0; wr_addr SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait for a fresh cs falling edge.

Verification
REQ-031 Write frame 0x83,0xA5 -> regs[3]=0xA5 within 4 clk of cs rise, one wr_strobe pulse, wr_addr=3, other regs 0.
REQ-032 Write frame 0x85,0x11 (addr 5 out of range) -> regs unchanged, one frame_err pulse, no wr_strobe.
REQ-033 15-bit write frame, then a 17-bit write frame -> each gives a frame_err pulse and leaves regs unchanged.
REQ-034 After writing regs[2]=0x3C, read frame 0x02,0x00 -> sdo bits 9..16 are 0,0,1,1,1,1,0,0, regs unchanged, no pulses.
REQ-035 Reset asserted after 10 bits of a write to addr 1 -> all outputs 0; the next valid frame 0x81,0x5A then gives regs[1]=0x5A.
REQ-036 Two back-to-back writes with 4-clk cs gap, with NUM_REGS=16, ADDR_W=4, DATA_W=16 -> both commit, two wr_strobe pulses.
